wb_gpio_bank: RTL and testbench
===============================

// Module: wb_gpio_bank
// PURPOSE
//  Wishbone B4 classic slave holding NUM_OUT output registers plus a synchronised input
//  port with sticky edge capture and interrupt. Every writable register decodes a mode field
//  from the address: write, set, clear, toggle. Sits on the peripheral bus for LEDs, keys and
//  control lines.
// PARAMETERS
//  DATA_WIDTH    32  bus and register width
//  SELECT_WIDTH   4  sel_i bits; granule G = DATA_WIDTH/SELECT_WIDTH
//  ADR_WIDTH      8  adr_i width (byte address)
//  NUM_OUT        2  output registers, 1..8
//  RESET_PAT      0  reset value of every output register
//  SYNC_STAGES    2  input synchroniser depth, >=2
//  EDGE_MODE      0  0 = rising, 1 = falling, 2 = both edges
// PORTS
//  clk_i    in   1                      bus clock; all state on posedge
//  reset    in   1                      reset, asynchronous, active-high
//  cyc_i    in   1                      wishbone cycle
//  stb_i    in   1                      wishbone strobe
//  we_i     in   1                      write enable
//  adr_i    in   ADR_WIDTH              byte address
//  sel_i    in   SELECT_WIDTH           granule selects
//  dat_i    in   DATA_WIDTH             write data
//  dat_o    out  DATA_WIDTH             read data, registered
//  ack_o    out  1                      normal termination, registered
//  err_o    out  1                      error termination, registered
//  rty_o    out  1                      tied 0
//  gpio_in  in   DATA_WIDTH             asynchronous inputs
//  gpio_out out  NUM_OUT*DATA_WIDTH     register k drives slice [k*DW +: DW]
//  irq_o    out  1                      level interrupt, registered
// BEHAVIOUR
//  Address fields: SB = clog2(SELECT_WIDTH); mode = adr_i[SB+1:SB].
//   R = adr_i[SB+2 +: clog2(NUM_OUT+3)].
//  Register map:
//   R < NUM_OUT   OUT[R], read/write.
//   R = NUM_OUT   IN, synchronised gpio_in, read-only.
//   R = NUM_OUT+1 EDGE, sticky status.
//   R = NUM_OUT+2 IEN, interrupt enable.
//   Other R values are unmapped.
//  Modes, applied per granule where sel_i[i]=1; unselected granules keep their value:
//   0: v = d    1: v = v | d    2: v = v & ~d    3: v = v ^ d
//   Mode is ignored on reads.
//  Handshake:
//   - term = cyc_i & stb_i & ~ack_o & ~err_o.
//   - ack_o/err_o assert the cycle after term and stay high exactly 1 cycle. Latency is 1.
//   - Back-to-back strobes are therefore answered every other cycle.
//   - The write commits on the same edge that raises ack_o.
//   - dat_o is loaded on that edge and holds until the next read; writes leave dat_o at 0.
//  err_o (instead of ack_o, no state change) for: write to IN; any access to unmapped R.
//   A read of IN/EDGE/IEN returns the current value; a write of IEN uses the modes.
//  Input path:
//   - SYNC_STAGES-flop synchroniser gives s; one extra flop gives p.
//   - edge = rise (s&~p), fall (~s&p) or both, per EDGE_MODE.
//   - EDGE <= (EDGE after SW write) | edge. A HW set wins over a SW clear in the same
//     cycle, so mode 2 works as write-1-to-clear.
//  irq_o <= |(EDGE & IEN), updated every cycle, one cycle behind the EDGE/IEN change.
//  Reset (async, any time, including mid-cycle):
//   - OUT = RESET_PAT; EDGE, IEN, sync flops, dat_o, ack_o, err_o, irq_o = 0.
//   - A pending transaction is dropped with no ack. The master must re-issue it.
//   - After release, first-cycle edges from the zeroed synchroniser are suppressed:
//     p is loaded from s for SYNC_STAGES+1 cycles.
// TESTING
//  T1 reset, read OUT0 (adr 0x00) -> ack 1 cycle later, dat_o = RESET_PAT, gpio_out[31:0] = 0.
//  T2 write 0x0000_00F0 adr 0x00; write 0x0000_000F adr 0x04 (set); write 0x0000_0030 adr 0x08
//     (clear); write 0x0000_0001 adr 0x0C (toggle) -> OUT0 = 0x0000_00CE.
//  T3 sel_i = 4'b0010, mode 0, dat_i = 0xAABB_CCDD to OUT1 -> only bits [15:8] become 0xCC.
//  T4 EDGE_MODE=0, IEN = 0x1, pulse gpio_in[0] 0->1 -> EDGE[0] set SYNC_STAGES+1 cycles later,
//     irq_o high 1 cycle after that; mode-2 write 0x1 to EDGE -> irq_o low; clear coinciding
//     with a new edge -> EDGE[0] stays 1.
//  T5 write to IN, and read of R = NUM_OUT+3 -> err_o 1 cycle, ack_o 0, no register changes.
//  T6 assert reset while stb_i is high before ack -> no ack or err, all registers at reset values.

Source files
------------

// File: rtl/wb_gpio_bank.sv
// ----------------------------------------------------------------------------
// wb_gpio_bank
//   Wishbone B4 classic slave with NUM_OUT output registers, a synchronised
//   input port, sticky edge capture and a level interrupt. Every writable
//   register decodes a mode field from the address: write, set, clear, toggle.
//
//   Address layout (byte address):
//     adr_i[SB+1:SB]         mode (0 write, 1 set, 2 clear, 3 toggle)
//     adr_i[SB+2 +: RW]      register index R
//   Register map:
//     R <  NUM_OUT           OUT[R]  read/write
//     R == NUM_OUT           IN      read-only (synchronised gpio_in)
//     R == NUM_OUT+1         EDGE    sticky edge status
//     R == NUM_OUT+2         IEN     interrupt enable
//     anything else          unmapped -> err_o
//
// Ports
//   clk_i     bus clock, all state on posedge
//   reset     asynchronous, active-high reset
//   cyc_i, stb_i, we_i, adr_i, sel_i, dat_i   wishbone request
//   dat_o, ack_o, err_o                       registered wishbone response
//   rty_o     tied low
//   gpio_in   asynchronous inputs
//   gpio_out  register k drives slice [k*DATA_WIDTH +: DATA_WIDTH]
//   irq_o     registered level interrupt, |(EDGE & IEN)
// ----------------------------------------------------------------------------
module wb_gpio_bank #(
   parameter int                    DATA_WIDTH   = 32,
   parameter int                    SELECT_WIDTH = 4,
   parameter int                    ADR_WIDTH    = 8,
   parameter int                    NUM_OUT      = 2,
   parameter logic [DATA_WIDTH-1:0] RESET_PAT    = '0,
   parameter int                    SYNC_STAGES  = 2,
   parameter int                    EDGE_MODE    = 0
) (
   input  logic                          clk_i,
   input  logic                          reset,
   input  logic                          cyc_i,
   input  logic                          stb_i,
   input  logic                          we_i,
   input  logic [ADR_WIDTH-1:0]          adr_i,
   input  logic [SELECT_WIDTH-1:0]       sel_i,
   input  logic [DATA_WIDTH-1:0]         dat_i,
   output logic [DATA_WIDTH-1:0]         dat_o,
   output logic                          ack_o,
   output logic                          err_o,
   output logic                          rty_o,
   input  logic [DATA_WIDTH-1:0]         gpio_in,
   output logic [NUM_OUT*DATA_WIDTH-1:0] gpio_out,
   output logic                          irq_o
);

   localparam int G  = DATA_WIDTH / SELECT_WIDTH;
   localparam int SB = $clog2(SELECT_WIDTH);
   localparam int RW = $clog2(NUM_OUT + 3);
   localparam int QW = $clog2(SYNC_STAGES + 2);
   localparam logic [QW-1:0] QUIET_DONE = QW'(SYNC_STAGES + 1);

   typedef enum logic [1:0] {
      MODE_WRITE  = 2'd0,
      MODE_SET    = 2'd1,
      MODE_CLEAR  = 2'd2,
      MODE_TOGGLE = 2'd3
   } mode_e;

   // Registers
   logic [NUM_OUT-1:0][DATA_WIDTH-1:0]     r_out;
   logic [DATA_WIDTH-1:0]                  r_edge;
   logic [DATA_WIDTH-1:0]                  r_ien;
   logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] r_sync;
   logic [DATA_WIDTH-1:0]                  r_prev;
   logic [QW-1:0]                          r_quiet;
   logic [DATA_WIDTH-1:0]                  r_dat;
   logic                                   r_ack;
   logic                                   r_err;
   logic                                   r_irq;

   // Decode / datapath wires
   mode_e                 w_mode;
   logic [RW-1:0]         w_reg;
   logic                  w_is_out;
   logic                  w_is_in;
   logic                  w_is_edge;
   logic                  w_is_ien;
   logic                  w_err;
   logic                  w_term;
   logic                  w_wr;
   logic [DATA_WIDTH-1:0] w_cur;
   logic [DATA_WIDTH-1:0] w_new;
   logic [DATA_WIDTH-1:0] w_s;
   logic [DATA_WIDTH-1:0] w_rise;
   logic [DATA_WIDTH-1:0] w_fall;
   logic [DATA_WIDTH-1:0] w_hw_edge;
   logic                  w_edge_en;
   logic                  w_unused;

   // Only the mode and register-index bits of the address are decoded.
   assign w_unused = ^adr_i;

   assign w_mode = mode_e'(adr_i[SB+1:SB]);
   assign w_reg  = adr_i[SB+2 +: RW];

   // Applies the address mode to the selected granules only.
   function automatic logic [DATA_WIDTH-1:0] apply_mode(
      input logic [DATA_WIDTH-1:0]   old_v,
      input logic [DATA_WIDTH-1:0]   d,
      input mode_e                   mode,
      input logic [SELECT_WIDTH-1:0] sel
   );
      logic [DATA_WIDTH-1:0] mask;
      logic [DATA_WIDTH-1:0] v;
      for (int i = 0; i < SELECT_WIDTH; i++) begin
         mask[i*G +: G] = {G{sel[i]}};
      end
      case (mode)
         MODE_WRITE:  v = d;
         MODE_SET:    v = old_v | d;
         MODE_CLEAR:  v = old_v & ~d;
         default:     v = old_v ^ d;
      endcase
      return (old_v & ~mask) | (v & mask);
   endfunction

   // NOTE: every signal assigned in always_comb gets a default first; a path
   // that leaves one unassigned would infer a latch.
   always_comb begin
      w_is_out  = 1'b0;
      w_cur     = '0;
      for (int k = 0; k < NUM_OUT; k++) begin
         if (w_reg == RW'(k)) begin
            w_is_out = 1'b1;
            w_cur    = r_out[k];
         end
      end
      w_is_in   = (w_reg == RW'(NUM_OUT));
      w_is_edge = (w_reg == RW'(NUM_OUT + 1));
      w_is_ien  = (w_reg == RW'(NUM_OUT + 2));
      if (w_is_in)   w_cur = w_s;
      if (w_is_edge) w_cur = r_edge;
      if (w_is_ien)  w_cur = r_ien;
      // IN is read-only; everything outside the map errors either way.
      w_err = ~(w_is_out | w_is_edge | w_is_ien | (w_is_in & ~we_i));
   end

   assign w_new  = apply_mode(w_cur, dat_i, w_mode, sel_i);
   assign w_term = cyc_i & stb_i & ~r_ack & ~r_err;
   assign w_wr   = w_term & we_i & ~w_err;

   // Input path: s is the synchroniser output, p is s one cycle later.
   assign w_s       = r_sync[SYNC_STAGES-1];
   assign w_rise    = w_s & ~r_prev;
   assign w_fall    = ~w_s & r_prev;
   assign w_edge_en = (r_quiet == QUIET_DONE);
   assign w_hw_edge = !w_edge_en      ? '0     :
                      (EDGE_MODE == 0) ? w_rise :
                      (EDGE_MODE == 1) ? w_fall :
                                         (w_rise | w_fall);

   // Synchroniser, previous-value flop and post-reset quiet window. Right
   // after reset the zeroed chain would look like an edge for every input
   // that is already high, so edge detection stays off until the chain and
   // p have been refilled from gpio_in.
   always_ff @(posedge clk_i or posedge reset) begin
      if (reset) begin
         r_sync  <= '0;
         r_prev  <= '0;
         r_quiet <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop
         // samples the pre-edge value; this is what makes the chain shift.
         r_sync[0] <= gpio_in;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            r_sync[i] <= r_sync[i-1];
         end
         r_prev <= w_s;
         if (r_quiet != QUIET_DONE) begin
            r_quiet <= r_quiet + 1'b1;
         end
      end
   end

   // Bus response and register file. A reset during a pending strobe simply
   // drops it: ack/err are cleared and the master has to re-issue.
   always_ff @(posedge clk_i or posedge reset) begin
      if (reset) begin
         // NOTE: the output register array is small and has a defined power-on
         // value, so it is reset like any other flop rather than left as RAM.
         r_out  <= {NUM_OUT{RESET_PAT}};
         r_edge <= '0;
         r_ien  <= '0;
         r_dat  <= '0;
         r_ack  <= 1'b0;
         r_err  <= 1'b0;
         r_irq  <= 1'b0;
      end else begin
         r_ack <= 1'b0;
         r_err <= 1'b0;
         if (w_term) begin
            if (w_err) begin
               r_err <= 1'b1;
               r_dat <= '0;
            end else begin
               r_ack <= 1'b1;
               r_dat <= we_i ? '0 : w_cur;
            end
         end

         for (int k = 0; k < NUM_OUT; k++) begin
            if (w_wr && w_is_out && (w_reg == RW'(k))) begin
               r_out[k] <= w_new;
            end
         end

         if (w_wr && w_is_ien) begin
            r_ien <= w_new;
         end

         // Hardware edges are ORed in after the software update, so a
         // clear and a new edge in the same cycle leave the bit set.
         r_edge <= ((w_wr && w_is_edge) ? w_new : r_edge) | w_hw_edge;

         r_irq <= |(r_edge & r_ien);
      end
   end

   assign gpio_out = r_out;
   assign dat_o    = r_dat;
   assign ack_o    = r_ack;
   assign err_o    = r_err;
   assign rty_o    = 1'b0;
   assign irq_o    = r_irq;

endmodule

// File: tb/tb_wb_gpio_bank.sv
// ----------------------------------------------------------------------------
// tb_wb_gpio_bank
//   Self-checking bench for wb_gpio_bank with default parameters
//   (DATA_WIDTH 32, NUM_OUT 2, rising-edge capture, 2-stage synchroniser).
//   Address map: OUT0 0x00, OUT1 0x10, IN 0x20, EDGE 0x30, IEN 0x40,
//   mode in adr[3:2]. Each bus transfer pushes its expected response into a
//   scoreboard queue; the entry is popped when ack/err arrives.
// ----------------------------------------------------------------------------
module tb_wb_gpio_bank;

   logic        clk_i = 1'b0;
   logic        reset = 1'b1;
   logic        cyc_i = 1'b0;
   logic        stb_i = 1'b0;
   logic        we_i  = 1'b0;
   logic [7:0]  adr_i = '0;
   logic [3:0]  sel_i = '0;
   logic [31:0] dat_i = '0;
   logic [31:0] dat_o;
   logic        ack_o;
   logic        err_o;
   logic        rty_o;
   logic [31:0] gpio_in = '0;
   logic [63:0] gpio_out;
   logic        irq_o;

   typedef struct {
      logic        err;
      logic        chk_dat;
      logic [31:0] dat;
      string       tag;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   wb_gpio_bank dut (
      .clk_i   (clk_i),
      .reset   (reset),
      .cyc_i   (cyc_i),
      .stb_i   (stb_i),
      .we_i    (we_i),
      .adr_i   (adr_i),
      .sel_i   (sel_i),
      .dat_i   (dat_i),
      .dat_o   (dat_o),
      .ack_o   (ack_o),
      .err_o   (err_o),
      .rty_o   (rty_o),
      .gpio_in (gpio_in),
      .gpio_out(gpio_out),
      .irq_o   (irq_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One classic transfer. Starts on the next falling edge, waits (bounded)
   // for a response, then checks the popped scoreboard entry and that the
   // response lasts exactly one cycle.
   task automatic bus(input string tag, input logic we, input logic [7:0] adr,
                      input logic [3:0] sel, input logic [31:0] dat,
                      input logic exp_err, input logic [31:0] exp_dat);
      exp_t e;
      int   lat;
      e.err     = exp_err;
      e.chk_dat = !exp_err;
      e.dat     = we ? 32'h0 : exp_dat;
      e.tag     = tag;
      sb_q.push_back(e);
      @(negedge clk_i);
      cyc_i = 1'b1; stb_i = 1'b1; we_i = we; adr_i = adr; sel_i = sel; dat_i = dat;
      lat = 0;
      do begin
         @(negedge clk_i);
         lat++;
      end while (!(ack_o || err_o) && lat < 8);
      cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
      check({tag, "_resp"}, 64'(ack_o | err_o), 64'd1);
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check({e.tag, "_lat"}, 64'(lat), 64'd1);
         check({e.tag, "_err"}, 64'(err_o), 64'(e.err));
         check({e.tag, "_ack"}, 64'(ack_o), 64'(!e.err));
         if (e.chk_dat) check({e.tag, "_dat"}, 64'(dat_o), 64'(e.dat));
      end
      @(negedge clk_i);
      check({tag, "_pulse"}, 64'(ack_o | err_o), 64'd0);
   endtask

   initial begin
      // T1: reset state and first read
      repeat (3) @(negedge clk_i);
      check("rst_gpio_out", gpio_out, 64'h0);
      check("rst_ack", 64'(ack_o), 64'd0);
      check("rst_irq", 64'(irq_o), 64'd0);
      check("rst_rty", 64'(rty_o), 64'd0);
      reset = 1'b0;
      bus("t1_rd_out0", 1'b0, 8'h00, 4'hF, 32'h0, 1'b0, 32'h0);
      check("t1_gpio_out0", 64'(gpio_out[31:0]), 64'h0);

      // T2: write, set, clear, toggle on OUT0
      bus("t2_wr",  1'b1, 8'h00, 4'hF, 32'h0000_00F0, 1'b0, 32'h0);
      bus("t2_set", 1'b1, 8'h04, 4'hF, 32'h0000_000F, 1'b0, 32'h0);
      bus("t2_clr", 1'b1, 8'h08, 4'hF, 32'h0000_0030, 1'b0, 32'h0);
      bus("t2_tgl", 1'b1, 8'h0C, 4'hF, 32'h0000_0001, 1'b0, 32'h0);
      check("t2_gpio_out0", 64'(gpio_out[31:0]), 64'h0000_00CE);
      bus("t2_rd", 1'b0, 8'h00, 4'hF, 32'h0, 1'b0, 32'h0000_00CE);

      // T3: partial select on OUT1 keeps unselected granules
      bus("t3_full", 1'b1, 8'h10, 4'hF, 32'h1122_3344, 1'b0, 32'h0);
      bus("t3_sel",  1'b1, 8'h10, 4'b0010, 32'hAABB_CCDD, 1'b0, 32'h0);
      check("t3_gpio_out1", 64'(gpio_out[63:32]), 64'h1122_CC44);
      bus("t3_rd", 1'b0, 8'h10, 4'hF, 32'h0, 1'b0, 32'h1122_CC44);

      // T4: edge capture, interrupt, write-1-to-clear and clear/edge race
      bus("t4_ien", 1'b1, 8'h40, 4'hF, 32'h1, 1'b0, 32'h0);
      gpio_in = 32'h1;
      repeat (3) @(negedge clk_i);
      check("t4_irq_early", 64'(irq_o), 64'd0);
      @(negedge clk_i);
      check("t4_irq_set", 64'(irq_o), 64'd1);
      bus("t4_rd_edge", 1'b0, 8'h30, 4'hF, 32'h0, 1'b0, 32'h1);
      bus("t4_w1c", 1'b1, 8'h38, 4'hF, 32'h1, 1'b0, 32'h0);
      check("t4_irq_clr", 64'(irq_o), 64'd0);
      bus("t4_rd_edge0", 1'b0, 8'h30, 4'hF, 32'h0, 1'b0, 32'h0);
      gpio_in = 32'h0;
      repeat (5) @(negedge clk_i);
      gpio_in = 32'h1;
      @(negedge clk_i);
      // The clear below commits on the same edge that captures the new rise.
      bus("t4_race_clr", 1'b1, 8'h38, 4'hF, 32'h1, 1'b0, 32'h0);
      bus("t4_rd_race", 1'b0, 8'h30, 4'hF, 32'h0, 1'b0, 32'h1);

      // T5: error terminations leave state alone
      bus("t5_wr_in", 1'b1, 8'h20, 4'hF, 32'hFFFF_FFFF, 1'b1, 32'h0);
      bus("t5_rd_unmapped", 1'b0, 8'h50, 4'hF, 32'h0, 1'b1, 32'h0);
      bus("t5_wr_unmapped", 1'b1, 8'h70, 4'hF, 32'hFFFF_FFFF, 1'b1, 32'h0);
      check("t5_gpio_out", gpio_out, 64'h1122_CC44_0000_00CE);
      bus("t5_rd_in",  1'b0, 8'h20, 4'hF, 32'h0, 1'b0, 32'h1);
      bus("t5_rd_ien", 1'b0, 8'h40, 4'hF, 32'h0, 1'b0, 32'h1);

      // T6: reset during a pending strobe drops it
      @(negedge clk_i);
      cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = 8'h00; sel_i = 4'hF;
      dat_i = 32'hDEAD_BEEF;
      #2 reset = 1'b1;
      repeat (2) @(negedge clk_i);
      check("t6_no_ack", 64'(ack_o), 64'd0);
      check("t6_no_err", 64'(err_o), 64'd0);
      check("t6_dat", 64'(dat_o), 64'h0);
      cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
      reset = 1'b0;
      repeat (4) @(negedge clk_i);
      check("t6_gpio_out", gpio_out, 64'h0);
      check("t6_irq", 64'(irq_o), 64'd0);
      // gpio_in[0] is still high: the refilled synchroniser must not flag it.
      bus("t6_rd_edge", 1'b0, 8'h30, 4'hF, 32'h0, 1'b0, 32'h0);
      bus("t6_rd_ien",  1'b0, 8'h40, 4'hF, 32'h0, 1'b0, 32'h0);
      bus("t6_rd_out1", 1'b0, 8'h10, 4'hF, 32'h0, 1'b0, 32'h0);
      check("sb_empty", 64'(sb_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "watchdog expired");
   end

endmodule
